// File: rtl/emux_txn_pkg.sv
// Shared definitions for the N-client UDP transmit multiplexer.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package emux_txn_pkg;

   // Bit positions inside the 10-bit octet word {m, p, d[7:0]}
   localparam int IN_M   = 9;
   localparam int IN_P   = 8;
   localparam int OCT_W  = 8;
   localparam int PORT_W = 16;
   localparam int LEN_W  = 16;

   // Source of the octet placed on the output register
   typedef enum logic [1:0] {
      MUX_PASS   = 2'd0,
      MUX_LEN_HI = 2'd1,
      MUX_LEN_LO = 2'd2,
      MUX_DATA   = 2'd3
   } mux_sel_e;

endpackage

// File: rtl/emux_txn_port_cmp.sv
// Two-stage UDP port comparator for one client: high octet registered, low octet live.
// Latency: o_lo is valid in the cycle the low port octet is presented.
// Backpressure: none; evaluates every octet of the stream.
module emux_port_cmp
   import emux_txn_pkg::*;
#(
   parameter logic [PORT_W-1:0] PORT = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic [OCT_W-1:0] i_d,
   input  logic             i_en,
   output logic             o_lo
);

   logic r_hi;

   // Remember whether the previous octet matched the high port byte
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_hi <= 1'b0;
      end else begin
         r_hi <= (i_d == PORT[15:8]);
      end
   end

   // Full-port hit: low byte now, high byte one octet earlier, client enabled
   assign o_lo = (i_d == PORT[7:0]) & r_hi & i_en;

endmodule

// File: rtl/emux_txn.sv
// N-client transmit mux: substitutes the selected client's length and payload into the UDP octet stream.
// Latency: in_c to out_c exactly 1 cycle; client data sampled on c_s, appears on out_c next cycle.
// Backpressure: none; clients must present data on c_s and a stable length on c_a.
module emux_txn
   import emux_txn_pkg::*;
#(
   parameter int                  NCH      = 4,
   parameter logic [16*NCH-1:0]   PORTS    = '0,
   parameter int                  jumbo_dw = 14,
   parameter int                  IDXW     = 4
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic [9:0]                in_c,
   output logic [9:0]                out_c,
   input  logic [8*NCH-1:0]          data,
   input  logic [jumbo_dw*NCH-1:0]   c_l,
   input  logic [NCH-1:0]            port_en,
   output logic [NCH-1:0]            c_w,
   output logic [NCH-1:0]            c_s,
   output logic [NCH-1:0]            c_a,
   output logic                      sel_valid,
   output logic [IDXW-1:0]           sel_idx,
   output logic [15:0]               pkt_cnt
);

   logic             w_in_m;
   logic             w_in_p;
   logic [OCT_W-1:0] w_in_d;
   logic [NCH-1:0]   w_lo;
   logic             w_hit;
   logic [IDXW-1:0]  w_hit_idx;
   logic [NCH-1:0]   w_sel_oh;
   logic [LEN_W-1:0] w_sel_len;
   logic [OCT_W-1:0] w_sel_dat;
   mux_sel_e         w_mux_sel;
   logic [OCT_W-1:0] w_mux;

   logic             r_sel_valid;
   logic [IDXW-1:0]  r_sel_idx;
   logic             r_in_l1;
   logic             r_in_l2;
   logic [LEN_W-1:0] r_len;
   logic             r_d_sel;
   logic [9:0]       r_out;
   logic [15:0]      r_pkt_cnt;

   assign w_in_m = in_c[IN_M];
   assign w_in_p = in_c[IN_P];
   assign w_in_d = in_c[OCT_W-1:0];

   // One comparator per client port
   for (genvar g = 0; g < NCH; g++) begin : g_cmp
      emux_port_cmp #(
         .PORT (PORTS[16*g +: 16])
      ) u_cmp (
         .i_clk (clk),
         .i_rst (rst),
         .i_d   (w_in_d),
         .i_en  (port_en[g]),
         .o_lo  (w_lo[g])
      );
   end

   // Priority encode port hits; scanning downwards lets the lowest index win
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = NCH - 1; i >= 0; i--) begin
         if (w_lo[i]) begin
            w_hit     = 1'b1;
            w_hit_idx = IDXW'(i);
         end
      end
   end

   // Decode the selected channel and pick out its length and payload octet
   always_comb begin
      w_sel_oh  = '0;
      w_sel_len = '0;
      w_sel_dat = '0;
      for (int i = 0; i < NCH; i++) begin
         if (r_sel_idx == IDXW'(i)) begin
            w_sel_oh[i] = 1'b1;
            w_sel_len   = LEN_W'(c_l[jumbo_dw*i +: jumbo_dw]);
            w_sel_dat   = data[8*i +: 8];
         end
      end
   end

   // Client handshakes only ever touch the selected channel
   assign c_w = w_sel_oh & {NCH{w_in_m & r_sel_valid}};
   assign c_s = w_sel_oh & {NCH{r_d_sel}};
   assign c_a = w_sel_oh & {NCH{r_in_l1 & r_sel_valid}};

   // Octet source: length bytes outrank payload, payload outranks pass-through
   always_comb begin
      w_mux_sel = MUX_PASS;
      if (r_in_l1 && r_sel_valid) begin
         w_mux_sel = MUX_LEN_HI;
      end else if (r_in_l2 && r_sel_valid) begin
         w_mux_sel = MUX_LEN_LO;
      end else if (r_d_sel) begin
         w_mux_sel = MUX_DATA;
      end
      case (w_mux_sel)
         MUX_LEN_HI: w_mux = w_sel_len[15:8];
         MUX_LEN_LO: w_mux = r_len[7:0];
         MUX_DATA:   w_mux = w_sel_dat;
         default:    w_mux = w_in_d;
      endcase
   end

   // Selection, length capture, payload strobe, output and packet counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_sel_valid <= 1'b0;
         r_sel_idx   <= '0;
         r_in_l1     <= 1'b0;
         r_in_l2     <= 1'b0;
         r_len       <= '0;
         r_d_sel     <= 1'b0;
         r_out       <= '0;
         r_pkt_cnt   <= '0;
      end else begin
         if (w_in_p) begin
            r_sel_valid <= w_hit;
            r_sel_idx   <= w_hit_idx;
         end
         r_in_l1 <= w_in_p;
         r_in_l2 <= r_in_l1;
         // Low length byte is taken from this copy so a late c_l change cannot tear it
         if (r_in_l1) begin
            r_len <= w_sel_len;
         end
         r_d_sel <= |c_w;
         r_out   <= {w_in_m, w_in_p, w_mux};
         if (r_in_l1 && r_sel_valid) begin
            r_pkt_cnt <= r_pkt_cnt + 16'd1;
         end
      end
   end

   assign out_c     = r_out;
   assign sel_valid = r_sel_valid;
   assign sel_idx   = r_sel_idx;
   assign pkt_cnt   = r_pkt_cnt;

endmodule

// File: tb/tb_emux_txn.sv
// Directed bench for emux_txn: UDP-like packets, scoreboarded output octets, handshake checks.
// Latency: expected octet pushed when driven, popped one cycle later.
// Backpressure: none.
module tb_emux_txn;

   logic        clk;
   logic        rst;
   logic [9:0]  in_c;
   logic [31:0] data;
   logic [55:0] c_l;
   logic [3:0]  port_en;

   logic [9:0]  out_c;
   logic [3:0]  c_w, c_s, c_a;
   logic        sel_valid;
   logic [3:0]  sel_idx;
   logic [15:0] pkt_cnt;

   logic [9:0]  d_out_c;
   logic [3:0]  d_c_w, d_c_s, d_c_a;
   logic        d_sel_valid;
   logic [3:0]  d_sel_idx;
   logic [15:0] d_pkt_cnt;

   int nvec = 0;
   int nerr = 0;
   int cnt_exp = 0;
   logic [9:0] sb[$];

   emux_txn #(
      .NCH      (4),
      .PORTS    ({16'd4000, 16'd3000, 16'd2000, 16'd1000}),
      .jumbo_dw (14),
      .IDXW     (4)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .in_c      (in_c),
      .out_c     (out_c),
      .data      (data),
      .c_l       (c_l),
      .port_en   (port_en),
      .c_w       (c_w),
      .c_s       (c_s),
      .c_a       (c_a),
      .sel_valid (sel_valid),
      .sel_idx   (sel_idx),
      .pkt_cnt   (pkt_cnt)
   );

   emux_txn #(
      .NCH      (4),
      .PORTS    ({16'd5000, 16'd7000, 16'd6000, 16'd5000}),
      .jumbo_dw (14),
      .IDXW     (4)
   ) dut_dup (
      .clk       (clk),
      .rst       (rst),
      .in_c      (in_c),
      .out_c     (d_out_c),
      .data      (data),
      .c_l       (c_l),
      .port_en   (port_en),
      .c_w       (d_c_w),
      .c_s       (d_c_s),
      .c_a       (d_c_a),
      .sel_valid (d_sel_valid),
      .sel_idx   (d_sel_idx),
      .pkt_cnt   (d_pkt_cnt)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish, got timeout required completion");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
      nvec++;
      assert (got === exp) else begin
         nerr++;
         $error("FAIL %s: observed %h expected %h", tag, got, exp);
      end
   endtask

   // One octet cycle: drive, optionally pulse reset, check handshakes, then check out_c
   task automatic step(input logic [9:0] c, input logic [9:0] eo, input logic [3:0] ecw,
                       input logic [3:0] ecs, input logic [3:0] eca, input logic [3:0] edca,
                       input bit rs);
      @(negedge clk);
      in_c = c;
      if (rs) begin
         #1 rst = 1'b1;
         #1 rst = 1'b0;
      end
      #1;
      chk("c_w", 16'(c_w), 16'(ecw));
      chk("c_s", 16'(c_s), 16'(ecs));
      chk("c_a", 16'(c_a), 16'(eca));
      chk("dup_c_a", 16'(d_c_a), 16'(edca));
      if (rs) begin
         chk("rst_out_c", 16'(out_c), 16'h0);
         chk("rst_sel_valid", 16'(sel_valid), 16'h0);
         chk("rst_pkt_cnt", pkt_cnt, 16'h0);
      end
      sb.push_back(eo);
      @(posedge clk);
      #1;
      chk("out_c", 16'(out_c), 16'(sb.pop_front()));
   endtask

   // One packet: src port, dst port (p on low byte), length, checksum, np payload octets, 2 idle
   task automatic pkt(input logic [15:0] port, input int sel, input int np, input int rst_at,
                      input bit tear, input bit en_drop, input logic [3:0] dca);
      logic [9:0]  c, eo;
      logic [7:0]  mux, db;
      logic [3:0]  oh, ecw, ecs, eca, edca;
      logic [15:0] lenw;
      logic [55:0] cl_save;
      bit          was_rst, rs, active;
      cl_save = c_l;
      was_rst = 1'b0;
      oh      = (sel >= 0) ? (4'b0001 << sel) : 4'b0000;
      lenw    = (sel >= 0) ? {2'b00, c_l[14*sel +: 14]} : 16'h0;
      for (int n = 0; n < 8 + np + 2; n++) begin
         if (n == 0)               c = 10'h012;
         else if (n == 1)          c = 10'h034;
         else if (n == 2)          c = {2'b00, port[15:8]};
         else if (n == 3)          c = {2'b01, port[7:0]};
         else if (n == 4)          c = 10'h077;
         else if (n == 5)          c = 10'h066;
         else if (n < 8)           c = 10'h000;
         else if (n < 8 + np)      c = {2'b10, 8'h50 + 8'(n - 8)};
         else                      c = 10'h000;
         for (int ch = 0; ch < 4; ch++) begin
            data[8*ch +: 8] = 8'h90 + 8'(16*ch) + 8'((n >= 9) ? n - 9 : 0);
         end
         if (tear && n == 5 && sel >= 0) c_l[14*sel +: 14] = 14'h0;
         if (en_drop && n == 5 && sel >= 0) port_en[sel] = 1'b0;
         rs     = (rst_at >= 0) && (n == 8 + rst_at);
         active = (sel >= 0) && !was_rst && !rs;
         db     = 8'h90 + 8'(16*((sel >= 0) ? sel : 0)) + 8'((n >= 9) ? n - 9 : 0);
         mux    = c[7:0];
         if (active) begin
            if (n == 4)                        mux = lenw[15:8];
            else if (n == 5)                   mux = lenw[7:0];
            else if (n >= 9 && n <= 8 + np)    mux = db;
         end
         eo   = {c[9:8], mux};
         ecw  = (active && c[9]) ? oh : 4'b0000;
         ecs  = (active && n >= 9 && n <= 8 + np) ? oh : 4'b0000;
         eca  = (active && n == 4) ? oh : 4'b0000;
         edca = (n == 4) ? dca : 4'b0000;
         step(c, eo, ecw, ecs, eca, edca, rs);
         if (rs) was_rst = 1'b1;
      end
      if (sel >= 0) cnt_exp++;
      if (rst_at >= 0) cnt_exp = 0;
      chk("pkt_cnt", pkt_cnt, 16'(cnt_exp));
      if (sel >= 0 && rst_at < 0) begin
         chk("sel_valid", 16'(sel_valid), 16'h1);
         chk("sel_idx", 16'(sel_idx), 16'(sel));
      end else begin
         chk("sel_valid_none", 16'(sel_valid), 16'h0);
      end
      c_l     = cl_save;
      port_en = 4'hF;
   endtask

   initial begin
      rst     = 1'b1;
      in_c    = '0;
      data    = '0;
      port_en = 4'hF;
      c_l     = {14'h3FFF, 14'h0123, 14'h0789, 14'h0456};
      @(negedge clk);
      #1;
      chk("reset_out_c", 16'(out_c), 16'h0);
      chk("reset_c_w", 16'(c_w), 16'h0);
      chk("reset_c_s", 16'(c_s), 16'h0);
      chk("reset_c_a", 16'(c_a), 16'h0);
      chk("reset_sel_valid", 16'(sel_valid), 16'h0);
      chk("reset_sel_idx", 16'(sel_idx), 16'h0);
      chk("reset_pkt_cnt", pkt_cnt, 16'h0);
      rst = 1'b0;

      // Port 3000 -> channel 2, length 0x0123
      pkt(16'd3000, 2, 2, -1, 1'b0, 1'b0, 4'b0000);
      // Same packet with channel 2 disabled: pure pass-through
      port_en = 4'b1011;
      pkt(16'd3000, -1, 2, -1, 1'b0, 1'b0, 4'b0000);
      // Five payload octets to channel 1, client counter 0xA0..0xA4
      pkt(16'd2000, 1, 5, -1, 1'b0, 1'b0, 4'b0000);
      // Duplicate port 5000 in the second instance: only channel 0 served
      pkt(16'd5000, -1, 1, -1, 1'b0, 1'b0, 4'b0001);
      chk("dup_sel_valid", 16'(d_sel_valid), 16'h1);
      chk("dup_sel_idx", 16'(d_sel_idx), 16'h0);
      // Length 0x3FFF dropped to 0 after capture must still go out as 3F FF
      pkt(16'd4000, 3, 0, -1, 1'b1, 1'b0, 4'b0000);
      // Reset pulsed on the third payload octet
      pkt(16'd2000, 1, 5, 2, 1'b0, 1'b0, 4'b0000);
      // Next packet served normally; enable drop mid-packet does not deselect
      pkt(16'd1000, 0, 3, -1, 1'b0, 1'b1, 4'b0000);

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
      $finish;
   end

endmodule
